// File: rtl/pio_pkg.sv
// Shared register map and edge-mode encodings for the PIO peripherals.
package pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage

// File: rtl/pio_debounce.sv
// Two-flop input synchronizer followed by a tick-sampled debouncer.
module pio_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_async,
    output logic [WIDTH-1:0] deb
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = in_async;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign deb = sync2_q;
        end else begin : g_deb
            localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

            logic [CW-1:0]    cnt_q, cnt_d;
            logic [WIDTH-1:0] smp_q, smp_d;
            logic [WIDTH-1:0] deb_q, deb_d;
            logic [WIDTH-1:0] differ;
            logic             tick;

            always_comb begin
                tick   = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
                cnt_d  = tick ? '0 : cnt_q + 1'b1;
                smp_d  = smp_q;
                deb_d  = deb_q;
                differ = sync2_q ^ smp_q;
                // A bit follows only if it matched at two consecutive ticks
                if (tick) begin
                    smp_d = sync2_q;
                    deb_d = (deb_q & differ) | (smp_q & ~differ);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                    smp_q <= '0;
                    deb_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    smp_q <= smp_d;
                    deb_q <= deb_d;
                end
            end

            assign deb = deb_q;
        end
    endgenerate

endmodule

// File: rtl/button_pio.sv
// Avalon-MM input PIO: debounced inputs, edge capture flags, maskable irq.
module button_pio
    import pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_prev_q, deb_prev_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0] rise, fall, edge_hit, clr;
    logic             wr_en, rd_en;
    logic             unused_wd;

    assign unused_wd = ^writedata;

    pio_debounce #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .in_async(in_port),
        .deb     (deb)
    );

    always_comb begin
        wr_en = chipselect && !write_n;
        rd_en = chipselect && write_n;
        rise  = deb & ~deb_prev_q;
        fall  = ~deb & deb_prev_q;
        case (EDGE_TYPE)
            int'(EDGE_RISE): edge_hit = rise;
            int'(EDGE_FALL): edge_hit = fall;
            int'(EDGE_ANY):  edge_hit = rise | fall;
            default:         edge_hit = rise;
        endcase

        clr    = '0;
        mask_d = mask_q;
        if (wr_en && address == PIO_ADDR_IRQMASK) mask_d = writedata[WIDTH-1:0];
        if (wr_en && address == PIO_ADDR_EDGECAP) clr = writedata[WIDTH-1:0];
        // New edges win over a simultaneous W1C so no event is lost
        ecap_d     = (ecap_q & ~clr) | edge_hit;
        deb_prev_d = deb;

        rdata_d = rdata_q;
        if (rd_en) begin
            unique case (address)
                PIO_ADDR_DATA:    rdata_d = 32'(deb);
                PIO_ADDR_IRQMASK: rdata_d = 32'(mask_q);
                PIO_ADDR_EDGECAP: rdata_d = 32'(ecap_q);
                default:          rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_prev_q <= '0;
            mask_q     <= '0;
            ecap_q     <= '0;
            rdata_q    <= '0;
        end else begin
            deb_prev_q <= deb_prev_d;
            mask_q     <= mask_d;
            ecap_q     <= ecap_d;
            rdata_q    <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(ecap_q & mask_q);

endmodule

// File: tb/tb_button_pio.sv
// Randomised and directed bench for button_pio across edge modes and debounce.
module tb_button_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;

    logic [31:0] rdata [4];
    logic        irq_o [4];

    int n_pass = 0;
    int n_total = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    // inst 0: rising, 1: falling, 2: any edge, 3: rising with 8-cycle debounce
    for (genvar g = 0; g < 4; g++) begin : g_dut
        button_pio #(
            .WIDTH          (4),
            .EDGE_TYPE      ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
            .DEBOUNCE_CYCLES((g == 3) ? 8 : 0)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .address   (address),
            .chipselect(chipselect),
            .write_n   (write_n),
            .writedata (writedata),
            .in_port   (in_port),
            .readdata  (rdata[g]),
            .irq       (irq_o[g])
        );
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: inputs seen 1 and 2 edges ago, edges since reset
    logic [3:0]  q1, q2, tsmp;
    int          since;
    logic [3:0]  m_deb [4];
    logic [3:0]  m_prev [4];
    logic [3:0]  m_ecap [4];
    logic [3:0]  m_mask [4];
    logic [31:0] m_rd [4];

    always @(posedge clk) begin
        logic       tk;
        logic [3:0] d, ev, clr, st;
        if (reset) begin
            q1 <= '0;
            q2 <= '0;
            tsmp <= '0;
            since <= 0;
            armed <= 1'b1;
            for (int k = 0; k < 4; k++) begin
                m_deb[k] <= '0;
                m_prev[k] <= '0;
                m_ecap[k] <= '0;
                m_mask[k] <= '0;
                m_rd[k] <= '0;
            end
        end else begin
            tk = (since % 8) == 7;
            for (int k = 0; k < 4; k++) begin
                d = m_deb[k];
                if (k == 1) ev = ~d & m_prev[k];
                else if (k == 2) ev = d ^ m_prev[k];
                else ev = d & ~m_prev[k];
                if (chipselect && write_n) begin
                    case (address)
                        2'd0: m_rd[k] <= 32'(d);
                        2'd2: m_rd[k] <= 32'(m_mask[k]);
                        2'd3: m_rd[k] <= 32'(m_ecap[k]);
                        default: m_rd[k] <= '0;
                    endcase
                end
                clr = '0;
                if (chipselect && !write_n && address == 2'd2) m_mask[k] <= writedata[3:0];
                if (chipselect && !write_n && address == 2'd3) clr = writedata[3:0];
                m_ecap[k] <= (m_ecap[k] & ~clr) | ev;
                m_prev[k] <= d;
                if (k != 3) begin
                    m_deb[k] <= q1;
                end else if (tk) begin
                    st = ~(q2 ^ tsmp);
                    m_deb[k] <= (d & ~st) | (q2 & st);
                end
            end
            if (tk) tsmp <= q2;
            q2 <= q1;
            q1 <= in_port;
            since <= since + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("readdata[%0d]", k), rdata[k], m_rd[k]);
                check($sformatf("irq[%0d]", k), 32'(irq_o[k]), 32'(|(m_ecap[k] & m_mask[k])));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n = 1'b0;
        address = a;
        writedata = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        chipselect = 1'b1;
        write_n = 1'b1;
        address = a;
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    initial begin
        int b;
        reset = 1'b1;
        chipselect = 1'b0;
        write_n = 1'b1;
        address = '0;
        writedata = '0;
        in_port = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset readdata", rdata[0], 32'h0);
        check("reset irq", 32'(irq_o[0]), 32'h0);

        reset = 1'b0;
        chipselect = 1'b1;
        address = 2'd0;
        idle(4);
        check("data after reset", rdata[0], 32'hF);
        bus_rd(2'd3);
        check("edgecap after reset", rdata[0], 32'hF);

        bus_wr(2'd2, 32'h2);
        in_port = 4'hD;
        idle(4);
        bus_wr(2'd3, 32'hF);
        check("irq after clear", 32'(irq_o[0]), 32'h0);
        in_port = 4'hF;
        idle(4);
        bus_rd(2'd3);
        check("edgecap bit1", rdata[0], 32'h2);
        check("model edgecap bit1", 32'(m_ecap[0]), 32'h2);
        check("irq bit1", 32'(irq_o[0]), 32'h1);
        bus_wr(2'd3, 32'h2);
        check("irq after w1c", 32'(irq_o[0]), 32'h0);
        bus_wr(2'd0, 32'h0);
        bus_rd(2'd0);
        check("data write ignored", rdata[0], 32'hF);

        in_port = 4'hE;
        idle(4);
        bus_wr(2'd2, 32'h1);
        bus_wr(2'd3, 32'hF);
        in_port = 4'hF;
        idle(2);
        bus_wr(2'd3, 32'h1);
        check("collision irq", 32'(irq_o[0]), 32'h1);
        bus_rd(2'd3);
        check("collision edgecap", rdata[0], 32'h1);

        in_port = 4'hB;
        idle(4);
        bus_wr(2'd3, 32'hF);
        in_port = 4'hF;
        idle(4);
        bus_rd(2'd3);
        check("fall mode on rise", rdata[1], 32'h0);
        check("any mode on rise", rdata[2], 32'h4);
        in_port = 4'hB;
        idle(4);
        bus_rd(2'd3);
        check("fall mode on fall", rdata[1], 32'h4);
        check("any mode on fall", rdata[2], 32'h4);

        in_port = 4'h0;
        idle(40);
        bus_wr(2'd3, 32'hF);
        in_port = 4'h8;
        idle(5);
        in_port = 4'h0;
        idle(20);
        bus_rd(2'd0);
        check("glitch data", rdata[3], 32'h0);
        bus_rd(2'd3);
        check("glitch edgecap", rdata[3], 32'h0);
        in_port = 4'h8;
        idle(20);
        bus_rd(2'd0);
        check("held data", rdata[3], 32'h8);
        bus_rd(2'd3);
        check("held edgecap", rdata[3], 32'h8);

        bus_rd(2'd1);
        check("reserved read", rdata[0], 32'h0);
        bus_wr(2'd2, 32'hFF);
        bus_rd(2'd2);
        check("irqmask width", rdata[0], 32'h0000000F);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            chipselect = $urandom_range(0, 1) == 1;
            write_n = $urandom_range(0, 2) != 0;
            address = 2'($urandom_range(0, 3));
            writedata = $urandom;
            if ($urandom_range(0, 24) == 0) begin
                b = $urandom_range(0, 3);
                in_port[b] = ~in_port[b];
            end
            @(negedge clk);
        end
        reset = 1'b0;
        chipselect = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
